// File: rtl/ori_hist_accum.sv
// Orientation histogram accumulator: sums gradient magnitudes into 32 saturating bins per
// keypoint window, then scans one bin per cycle to find the dominant orientation.
module ori_hist_accum #(
  parameter int unsigned DIR_W = 5,
  parameter int unsigned MAG_W = 8,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIR_W-1:0] in_dir,
  input  logic [MAG_W-1:0] in_mag,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIR_W-1:0] peak_dir,
  output logic [ACC_W-1:0] peak_val,
  output logic [15:0]      samp_cnt
);

  localparam int unsigned NBINS = 2 ** DIR_W;
  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {StAcc, StScan, StDone} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] bins_q [NBINS];
  logic [15:0]      cnt_q;
  logic [DIR_W-1:0] idx_q;
  logic [DIR_W-1:0] max_dir_q;
  logic [ACC_W-1:0] max_val_q;

  logic             accept;
  logic             take;
  logic [SUM_W-1:0] sum;
  logic [ACC_W-1:0] sat_val;
  logic [15:0]      cnt_inc;
  logic             scan_gt;
  logic [DIR_W-1:0] new_dir;
  logic [ACC_W-1:0] new_val;

  always_comb begin
    accept  = in_valid & in_ready;
    take    = out_valid & out_ready;
    // One extra bit catches the carry so the bin can clamp instead of wrapping.
    sum     = {1'b0, bins_q[in_dir]} + SUM_W'(in_mag);
    sat_val = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    // Strict compare keeps the earliest (lowest-index) bin on ties.
    scan_gt = bins_q[idx_q] > max_val_q;
    new_dir = scan_gt ? idx_q : max_dir_q;
    new_val = scan_gt ? bins_q[idx_q] : max_val_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StAcc;
      bins_q    <= '{default: '0};
      cnt_q     <= '0;
      idx_q     <= '0;
      max_dir_q <= '0;
      max_val_q <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      peak_dir  <= '0;
      peak_val  <= '0;
      samp_cnt  <= '0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (accept) begin
            bins_q[in_dir] <= sat_val;
            cnt_q          <= cnt_inc;
            if (in_last) begin
              samp_cnt  <= cnt_inc;
              idx_q     <= '0;
              max_dir_q <= '0;
              max_val_q <= '0;
              in_ready  <= 1'b0;
              state_q   <= StScan;
            end
          end
        end
        StScan: begin
          max_dir_q <= new_dir;
          max_val_q <= new_val;
          idx_q     <= idx_q + DIR_W'(1);
          if (&idx_q) begin
            peak_dir  <= new_dir;
            peak_val  <= new_val;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (take) begin
            bins_q    <= '{default: '0};
            cnt_q     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StAcc;
          end
        end
        default: begin
          state_q   <= StAcc;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ori_hist_accum.sv
// Randomized scoreboard bench for ori_hist_accum against a behavioural histogram model.
module tb_ori_hist_accum;

  localparam int DIR_W = 5;
  localparam int MAG_W = 8;
  localparam int ACC_W = 16;
  localparam int NBINS = 32;
  localparam int ACC_MAX = 65535;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DIR_W-1:0] in_dir = '0;
  logic [MAG_W-1:0] in_mag = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DIR_W-1:0] peak_dir;
  logic [ACC_W-1:0] peak_val;
  logic [15:0]      samp_cnt;

  ori_hist_accum #(.DIR_W(DIR_W), .MAG_W(MAG_W), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_dir   (in_dir),
    .in_mag   (in_mag),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .peak_dir (peak_dir),
    .peak_val (peak_val),
    .samp_cnt (samp_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int dir;
    int val;
    int cnt;
    int acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mbins[NBINS];
  int   mcnt = 0;
  bit   hold_ready = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    foreach (mbins[i]) mbins[i] = 0;
    mcnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'($urandom_range(0, 1));
    in_dir   = DIR_W'($urandom_range(0, NBINS - 1));
    in_mag   = MAG_W'($urandom_range(0, 255));
    step();
    in_last = 1'b0;
  endtask

  // Drives one sample; the model tracks it and, on the last sample, queues the expected peak.
  task automatic send(input int d, input int m, input bit last, input bit keep);
    int guard = 0;
    int bd = 0;
    int bv = 0;
    while (!in_ready && guard < 200) begin
      step();
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_dir   = DIR_W'(d);
    in_mag   = MAG_W'(m);
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    mbins[d] = (mbins[d] + m > ACC_MAX) ? ACC_MAX : mbins[d] + m;
    mcnt     = (mcnt < 65535) ? mcnt + 1 : mcnt;
    if (last) begin
      if (keep) begin
        for (int i = 0; i < NBINS; i++) begin
          if (mbins[i] > bv) begin
            bv = mbins[i];
            bd = i;
          end
        end
        sb.push_back('{dir: bd, val: bv, cnt: mcnt, acc_cyc: cyc});
      end
      model_clear();
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((sb.size() != 0 || out_valid) && g < 3000) begin
      step();
      g++;
    end
    if (g >= 3000) begin
      check("drain_timeout", 0, 1);
      sb.delete();
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard when a result appears, then checks it stays put until taken.
  bit   pv = 1'b0;
  int   cdir = 0;
  int   cval = 0;
  int   ccnt = 0;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (out_valid && !pv) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check("peak_dir", int'(peak_dir), e.dir);
          check("peak_val", int'(peak_val), e.val);
          check("samp_cnt", int'(samp_cnt), e.cnt);
          check("latency", cyc - e.acc_cyc, 32);
        end
        cdir = int'(peak_dir);
        cval = int'(peak_val);
        ccnt = int'(samp_cnt);
        check("in_ready_done", int'(in_ready), 0);
      end else if (out_valid) begin
        check("hold_peak_dir", int'(peak_dir), cdir);
        check("hold_peak_val", int'(peak_val), cval);
        check("hold_samp_cnt", int'(samp_cnt), ccnt);
        check("hold_in_ready", int'(in_ready), 0);
      end else if (pv) begin
        check("retain_peak_dir", int'(peak_dir), cdir);
        check("retain_peak_val", int'(peak_val), cval);
        check("retain_samp_cnt", int'(samp_cnt), ccnt);
      end
      pv = out_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int g;
    model_clear();
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_peak_dir", int'(peak_dir), 0);
    check("rst_peak_val", int'(peak_val), 0);
    check("rst_samp_cnt", int'(samp_cnt), 0);
    hold_ready = 1'b0;

    // Basic accumulation
    send(5, 10, 1'b0, 1'b1);
    idle();
    send(5, 20, 1'b0, 1'b1);
    send(17, 25, 1'b1, 1'b1);
    wait_drain();

    // Tie goes to the lowest index
    send(7, 40, 1'b0, 1'b1);
    send(2, 40, 1'b1, 1'b1);
    wait_drain();

    // Wrapped ROM directions
    for (int i = 0; i < 16; i++) send((24 + i) % NBINS, i + 1, i == 15, 1'b1);
    wait_drain();

    // Bin saturation
    for (int i = 0; i < 300; i++) send(31, 255, i == 299, 1'b1);
    wait_drain();

    // Zero window
    send(0, 0, 1'b1, 1'b1);
    wait_drain();

    // Backpressure with ignored input while the result is held
    hold_ready = 1'b1;
    send(12, 77, 1'b0, 1'b1);
    send(4, 3, 1'b1, 1'b1);
    g = 0;
    while (!out_valid && g < 100) begin
      step();
      g++;
    end
    check("bp_out_valid_rise", int'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_dir   = DIR_W'($urandom_range(0, NBINS - 1));
      in_mag   = 8'd255;
      in_last  = 1'b1;
      step();
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
    end
    in_valid   = 1'b0;
    in_last    = 1'b0;
    hold_ready = 1'b0;
    wait_drain();
    send(0, 1, 1'b1, 1'b1);
    wait_drain();

    // Reset in the middle of a scan discards the window
    send(9, 200, 1'b0, 1'b0);
    send(9, 100, 1'b1, 1'b0);
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    check("midscan_rst_out_valid", int'(out_valid), 0);
    check("midscan_rst_in_ready", int'(in_ready), 1);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_out_valid", int'(out_valid), 0);
    check("post_rst_peak_val", int'(peak_val), 0);
    check("post_rst_samp_cnt", int'(samp_cnt), 0);
    repeat (40) step();
    check("post_rst_no_result", int'(out_valid), 0);
    model_clear();
    send(3, 9, 1'b1, 1'b1);
    wait_drain();

    // Random windows; some confined to few bins to provoke ties
    for (int w = 0; w < 14; w++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle();
        if (w % 2 == 0)
          send($urandom_range(0, NBINS - 1), $urandom_range(0, 255), i == n - 1, 1'b1);
        else
          send($urandom_range(0, 3) * 8, $urandom_range(1, 2) * 16, i == n - 1, 1'b1);
      end
      wait_drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
